// File: rtl/sparse_bitserial_mac_ctrl_if.sv
// Operand, mux and result signals of the sparse bit-serial MAC controller.
// master: fetch stage / mux / adder tree side; slave: the controller.
interface sparse_bitserial_mac_ctrl_if #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [15:0]             act_vec;
    logic [3:0]              w_mask;
    logic [15:0]             w_val;
    logic [3:0]              mux_act;
    logic [1:0]              mux_idx;
    logic                    mux_sel;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] result;
    logic [CNT_W-1:0]        busy_cycles;

    modport master (
        output in_valid, act_vec, w_mask, w_val, mux_sel, out_ready,
        input  in_ready, mux_act, mux_idx, out_valid, result, busy_cycles
    );

    modport slave (
        input  in_valid, act_vec, w_mask, w_val, mux_sel, out_ready,
        output in_ready, mux_act, mux_idx, out_valid, result, busy_cycles
    );
endinterface

// File: rtl/sparse_bitserial_mac_ctrl.sv
// Sparse bit-serial MAC sequencer: walks the nonzero weight positions of one
// 4-element dot product, one activation bit plane at a time (LSB first), and
// accumulates sign-extended weights shifted by the plane index whenever the
// external 4:1 mux returns a set bit.
module sparse_bitserial_mac_ctrl #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    sparse_bitserial_mac_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [15:0]             act_q, w_q;
    logic [3:0]              mask_q;
    logic [1:0]              plane, pos;
    logic signed [ACC_W-1:0] acc, acc_nxt, result_q, w_ext;
    logic [CNT_W-1:0]        cnt, cnt_nxt, busy_q;
    logic [3:0]              w_sel, plane_bits, mask_above;
    logic                    accept, finish, hi_found;
    logic [1:0]              hi_idx, lo_in, lo_q;

    // Index of the lowest set bit (0 when the mask is empty; callers test that separately)
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else if (m[3]) return 2'd3;
        else           return 2'd0;
    endfunction

    // Position walk, current-plane mux bits and the accumulate candidate
    always_comb begin
        mask_above = mask_q & (4'b1110 << pos);
        hi_found   = |mask_above;
        hi_idx     = lowest_set(mask_above);
        lo_q       = lowest_set(mask_q);
        lo_in      = lowest_set(bus.w_mask);
        plane_bits = {act_q[{2'b11, plane}], act_q[{2'b10, plane}],
                      act_q[{2'b01, plane}], act_q[{2'b00, plane}]};
        w_sel      = w_q[{pos, 2'b00} +: 4];
        w_ext      = ACC_W'(signed'(w_sel));
        acc_nxt    = bus.mux_sel ? acc + (w_ext <<< plane) : acc;
        cnt_nxt    = (&cnt) ? cnt : cnt + 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state; clr takes priority over any handshake in the same cycle
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = (bus.w_mask == '0) ? DONE : RUN;
                end
                RUN: if (!hi_found && plane == 2'd3) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
                DONE: if (bus.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand latch, accumulation and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q    <= '0;
            w_q      <= '0;
            mask_q   <= '0;
            plane    <= '0;
            pos      <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
            busy_q   <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (accept) begin
            act_q  <= bus.act_vec;
            w_q    <= bus.w_val;
            mask_q <= bus.w_mask;
            plane  <= '0;
            pos    <= lo_in;
            acc    <= '0;
            cnt    <= '0;
            if (bus.w_mask == '0) begin
                result_q <= '0;
                busy_q   <= '0;
            end
        end else if (state == RUN) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (hi_found) begin
                pos <= hi_idx;
            end else begin
                plane <= plane + 2'd1;
                pos   <= lo_q;
            end
            // Result is captured from the final accumulate so it is valid on DONE entry
            if (finish) begin
                result_q <= acc_nxt;
                busy_q   <= cnt_nxt;
            end
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.mux_act     = (state == RUN) ? plane_bits : '0;
    assign bus.mux_idx     = (state == RUN) ? pos : '0;
    assign bus.result      = result_q;
    assign bus.busy_cycles = busy_q;
endmodule

// File: tb/tb_sparse_bitserial_mac_ctrl.sv
// Bench for the sparse bit-serial MAC controller: directed scenarios plus
// random packets compared against an arithmetic dot-product model.
module tb_sparse_bitserial_mac_ctrl;
    localparam int ACC_W = 12;
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    logic clr;
    int   checks   = 0;
    int   errors   = 0;
    int   last_res = 0;

    sparse_bitserial_mac_ctrl_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    // The bench plays the 4:1 bit-select mux
    assign bus.mux_sel = bus.mux_act[bus.mux_idx];

    sparse_bitserial_mac_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int act_of(input logic [15:0] a, input int k);
        return int'(a[4*k +: 4]);
    endfunction

    function automatic int wt_of(input logic [15:0] w, input int k);
        int v;
        v = int'(w[4*k +: 4]);
        return (v > 7) ? v - 16 : v;
    endfunction

    function automatic int dot_ref(input logic [15:0] a, input logic [3:0] m, input logic [15:0] w);
        int s = 0;
        for (int k = 0; k < 4; k++) if (m[k]) s += act_of(a, k) * wt_of(w, k);
        return s;
    endfunction

    function automatic int plane_ref(input logic [15:0] a, input int b);
        int r = 0;
        for (int k = 0; k < 4; k++) r |= ((act_of(a, k) >> b) & 1) << k;
        return r;
    endfunction

    // Drive one packet from IDLE (called at a negedge) through to acceptance of its result
    task automatic run_packet(input logic [15:0] a, input logic [3:0] m, input logic [15:0] w,
                              input int hold, input string name);
        int p, lat, n, exp_res;
        int bits[$];
        bit done;
        p = 0;
        for (int k = 0; k < 4; k++) if (m[k]) begin bits.push_back(k); p++; end
        exp_res = dot_ref(a, m, w);
        check({name, ":in_ready_idle"}, int'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.act_vec   = a;
        bus.w_mask    = m;
        bus.w_val     = w;
        bus.out_ready = 1'b0;
        lat  = 0;
        done = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'($urandom);
            bus.act_vec  = 16'($urandom);
            bus.w_mask   = 4'($urandom);
            bus.w_val    = 16'($urandom);
            lat++;
            @(negedge clk);
            if (bus.out_valid) begin
                done = 1;
            end else if (p > 0) begin
                n = lat - 1;
                check({name, ":mux_idx"}, int'(bus.mux_idx), bits[n % p]);
                check({name, ":mux_act"}, int'(bus.mux_act), plane_ref(a, n / p));
                check({name, ":in_ready_run"}, int'(bus.in_ready), 0);
            end
        end
        check({name, ":latency"}, lat, 4 * p + 1);
        check({name, ":result"}, int'(bus.result), exp_res);
        check({name, ":busy"}, int'(bus.busy_cycles), 4 * p);
        check({name, ":done_idx"}, int'(bus.mux_idx), 0);
        check({name, ":done_act"}, int'(bus.mux_act), 0);
        check({name, ":in_ready_done"}, int'(bus.in_ready), 0);
        repeat (hold) begin
            bus.in_valid = 1'b1;
            bus.w_mask   = 4'($urandom);
            bus.act_vec  = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({name, ":hold_valid"}, int'(bus.out_valid), 1);
            check({name, ":hold_result"}, int'(bus.result), exp_res);
            check({name, ":hold_busy"}, int'(bus.busy_cycles), 4 * p);
            check({name, ":hold_in_ready"}, int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        check({name, ":drain_valid"}, int'(bus.out_valid), 0);
        check({name, ":drain_in_ready"}, int'(bus.in_ready), 1);
        check({name, ":kept_result"}, int'(bus.result), exp_res);
        last_res = exp_res;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.act_vec   = '0;
        bus.w_mask    = '0;
        bus.w_val     = '0;
        #2;
        check("rst:in_ready", int'(bus.in_ready), 1);
        check("rst:out_valid", int'(bus.out_valid), 0);
        check("rst:result", int'(bus.result), 0);
        check("rst:busy", int'(bus.busy_cycles), 0);
        check("rst:mux_act", int'(bus.mux_act), 0);
        check("rst:mux_idx", int'(bus.mux_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // a3..a0 = 15,0,5,3; w3=7, w2 unused, w1=-3, w0=2
        run_packet(16'hF053, 4'b1011, 16'h75D2, 0, "tp_basic");
        check("tp_basic:const_result", int'(bus.result), 96);
        check("tp_basic:const_busy", int'(bus.busy_cycles), 12);
        run_packet(16'($urandom), 4'b0000, 16'($urandom), 2, "tp_mask0");
        run_packet(16'hFFFF, 4'b1111, 16'h8888, 0, "tp_min");
        check("tp_min:const_result", int'(bus.result), -480);
        run_packet(16'hFFFF, 4'b1111, 16'h7777, 0, "tp_max");
        check("tp_max:const_result", int'(bus.result), 420);
        run_packet(16'($urandom), 4'b0110, 16'($urandom), 5, "tp_hold");

        // clr in RUN cycle 3 with a competing in_valid
        bus.in_valid = 1'b1;
        bus.act_vec  = 16'($urandom);
        bus.w_mask   = 4'b1111;
        bus.w_val    = 16'($urandom);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("clr:run_idx", int'(bus.mux_idx), 2);
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.w_mask   = 4'b0000;
        @(posedge clk);
        #1;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("clr:in_ready", int'(bus.in_ready), 1);
        check("clr:out_valid", int'(bus.out_valid), 0);
        check("clr:mux_act", int'(bus.mux_act), 0);
        check("clr:mux_idx", int'(bus.mux_idx), 0);
        check("clr:kept_result", int'(bus.result), last_res);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid || !bus.in_ready) bad++;
        end
        check("clr:stays_idle", bad, 0);
        run_packet(16'($urandom), 4'b1101, 16'($urandom), 1, "clr_next");

        // asynchronous reset in the middle of RUN
        bus.in_valid = 1'b1;
        bus.act_vec  = 16'hFFFF;
        bus.w_mask   = 4'b1111;
        bus.w_val    = 16'h7777;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst:in_ready", int'(bus.in_ready), 1);
        check("arst:out_valid", int'(bus.out_valid), 0);
        check("arst:result", int'(bus.result), 0);
        check("arst:busy", int'(bus.busy_cycles), 0);
        check("arst:mux_act", int'(bus.mux_act), 0);
        check("arst:mux_idx", int'(bus.mux_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_packet(16'h0900, 4'b0100, 16'h0F00, 1, "arst_next");
        check("arst_next:const_result", int'(bus.result), -9);
        check("arst_next:const_busy", int'(bus.busy_cycles), 4);

        for (int i = 0; i < 40; i++) begin
            run_packet(16'($urandom), 4'($urandom), 16'($urandom),
                       int'($urandom_range(0, 3)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sparse_bitserial_mac_ctrl.md
Name: sparse_bitserial_mac_ctrl

Overview:
- Sequences one 4-activation sparse dot product through the 4:1 bit-select mux.
- Activations are processed bit-serially, LSB plane first. For each plane, the block walks only the nonzero weight positions and drives each one to the mux.
- Weights are accumulated as sign-extended values shifted by the plane index.
- Sits between the weight/activation fetch stage and the partial-sum adder tree. Valid/ready handshake on both sides.

Parameters:
- ACC_W, 12, accumulator/result width (signed); must be at least 10.
- CNT_W, 8, width of the saturating busy-cycle counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort; returns the block to IDLE
- in_valid  in  1  operand packet valid
- in_ready  out  1  block can accept a packet
- act_vec  in  16  four unsigned 4-bit activations; act k = act_vec[4k+3:4k]
- w_mask  in  4  nonzero-weight mask; bit k set means weight k is nonzero
- w_val  in  16  four signed 4-bit weights; w k = w_val[4k+3:4k]
- mux_act  out  4  bit plane to the mux: {a3[b],a2[b],a1[b],a0[b]}
- mux_idx  out  2  position to the mux
- mux_sel  in  1  selected bit returned by the mux (combinational, same cycle)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- result  out  ACC_W  signed dot product
- busy_cycles  out  CNT_W  RUN cycles used by the last packet, saturating

Behaviour:
- Reset (rst_n low): state=IDLE, all registers cleared.
  - Outputs: in_ready=1, out_valid=0, result=0, busy_cycles=0, mux_act=0, mux_idx=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&in_ready: latch act_vec, w_mask and w_val; set plane=0, pos=lowest set bit of w_mask; clear acc and the cycle counter.
  - If w_mask==0, go to DONE with acc=0 and busy_cycles=0. Otherwise go to RUN.
- RUN (in_ready=0):
  - Each cycle drive mux_act = plane-b bits of the latched activations, and mux_idx=pos.
  - At the clock edge: if mux_sel=1, acc += sext(w[pos]) << plane. Cycle counter +1, saturating at all ones.
  - Advance pos to the next higher set bit of the mask.
  - If there is none, plane+1 and pos = lowest set bit.
  - After plane 3's last set bit, go to DONE.
  - RUN length is exactly 4*popcount(w_mask) cycles; no zero position is ever issued.
- Outside RUN, mux_act and mux_idx hold 0.
- DONE:
  - out_valid=1. result=acc and busy_cycles are registered and stable while out_valid=1.
  - On out_ready go to IDLE; in_ready rises the next cycle, so there is no same-cycle accept.
  - out_valid holds until accepted, regardless of in_valid.
- Latency: out_valid rises 4*popcount+1 cycles after the accept edge. With mask 0, it rises 1 cycle after.
- Arithmetic:
  - acc is signed ACC_W bits; the range is -480..+420, so no overflow is possible at ACC_W>=10.
  - Weights are sign-extended from bit 3; activations are unsigned.
- clr:
  - In any state: next state IDLE, acc=0, out_valid=0. The result register retains its last value.
  - clr overrides a same-cycle in_valid (no accept) and a same-cycle out_ready.
- Reset mid-RUN discards the packet immediately (asynchronous).
- Input signals are ignored outside IDLE. Latched operands are immune to input changes during RUN.

Test Plan:
- act_vec={15,0,5,3} (a3..a0), w_mask=4'b1011, w={7,x,-3,2} (w3..w0) -> 12 RUN cycles; mux_idx sequence 0,1,3 repeated per plane; result=96, busy_cycles=12, out_valid at accept+13.
- w_mask=4'b0000 with any data -> out_valid at accept+1, result=0, busy_cycles=0, mux_idx stays 0.
- All activations 15, all weights -8, mask 4'b1111 -> 16 RUN cycles, result=-480; all activations 15, weights 7 -> result=420.
- Hold out_ready=0 for 5 cycles after result with in_valid=1 -> out_valid and result stable, in_ready=0, no new accept; out_ready=1 -> IDLE, then accept on the following cycle.
- clr asserted at RUN cycle 3 together with in_valid=1 -> IDLE next cycle, out_valid never rises, no accept that cycle; the next packet computes correctly from acc=0.
- rst_n pulsed low mid-RUN -> all outputs at reset values asynchronously; after release, a fresh packet (mask 4'b0100, w2=-1, a2=9) -> result=-9, busy_cycles=4.
